// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's SQI memory arbiter.
package idli_pkg;

  // One nibble on the SQI bus.
  typedef logic [3:0] sqi_data_t;

  // Access sequencer states.
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t IDLE  = 3'd0;
  localparam arb_state_t CMD   = 3'd1;
  localparam arb_state_t ADDR  = 3'd2;
  localparam arb_state_t DUMMY = 3'd3;
  localparam arb_state_t DATA  = 3'd4;
  localparam arb_state_t DESEL = 3'd5;

  // SQI opcodes.
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  // Requester identities: fetch on port 0, load/store on port 1.
  typedef enum logic {
    ARB_FETCH = 1'b0,
    ARB_LSU   = 1'b1
  } arb_req_id_t;

endpackage

// File: rtl/idli_rr_arb_m.sv
// Two-input round-robin arbiter. The winner of each granted cycle is
// remembered so that a later tie goes to the other requester.
module idli_rr_arb_m
  import idli_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  arb_req_id_t last_q;
  arb_req_id_t gnt_id;

  // A lone requester wins; on a tie, whoever did not win last time wins.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = ARB_FETCH;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = ARB_FETCH;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = ARB_LSU;
      end
      2'b11: begin
        if (last_q == ARB_FETCH) begin
          gnt    = 2'b10;
          gnt_id = ARB_LSU;
        end else begin
          gnt    = 2'b01;
          gnt_id = ARB_FETCH;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = ARB_FETCH;
      end
    endcase
  end

  // Record the winner; reset marks LSU as last so fetch wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= ARB_LSU;
    end else if (upd && (req != 2'b00)) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/idli_sqi_arb_m.sv
// Shares one SQI serial memory between instruction fetch and load/store.
// Each granted access runs CMD -> ADDR -> (DUMMY) -> DATA -> DESEL.
module idli_sqi_arb_m
  import idli_pkg::*;
#(
  parameter int ADDR_NIBBLES  = 6,
  parameter int DUMMY_NIBBLES = 2,
  parameter int WORD_NIBBLES  = 4
) (
  input  logic             i_arb_gck,
  input  logic             i_arb_rst,
  input  logic [1:0]       i_arb_req,
  input  logic [1:0]       i_arb_wr,
  input  logic [1:0][15:0] i_arb_addr,
  input  sqi_data_t [1:0]  i_arb_wr_data,
  output logic [1:0]       o_arb_gnt,
  output logic [3:0]       o_arb_rd_data,
  output logic             o_arb_rd_vld,
  output logic             o_arb_wr_acp,
  output logic             o_arb_done,
  output logic             o_arb_cs,
  output logic [3:0]       o_arb_sio,
  output logic             o_arb_sio_oe,
  input  logic [3:0]       i_arb_sio
);

  localparam int ADDR_BITS = 4 * ADDR_NIBBLES;
  localparam int SH_W      = 8 + ADDR_BITS;

  // Counter reload values: each phase counts down to zero.
  localparam logic [7:0] CMD_LAST   = 8'd1;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
  localparam logic [7:0] WORD_LAST  = 8'(WORD_NIBBLES - 1);

  arb_state_t      state_q;
  logic [7:0]      cnt_q;
  logic [1:0]      gnt_q;
  logic            wr_q;
  logic [SH_W-1:0] shift_q;

  logic            in_idle;
  logic            last_cnt;
  logic [1:0]      rr_req;
  logic [1:0]      rr_gnt;
  logic [15:0]     sel_addr;
  logic            sel_wr;
  logic            rd_sample;

  assign in_idle   = (state_q == IDLE);
  assign last_cnt  = (cnt_q == 8'd0);
  assign rr_req    = in_idle ? i_arb_req : 2'b00;
  assign sel_addr  = rr_gnt[1] ? i_arb_addr[1] : i_arb_addr[0];
  assign sel_wr    = rr_gnt[1] ? i_arb_wr[1] : i_arb_wr[0];
  assign rd_sample = (state_q == DATA) && !wr_q;
  assign o_arb_gnt = gnt_q;

  idli_rr_arb_m u_rr_arb (
    .clock (i_arb_gck),
    .reset (i_arb_rst),
    .req   (rr_req),
    .upd   (in_idle),
    .gnt   (rr_gnt)
  );

  // Sequencer: latch the winner's request at grant, then walk the phases.
  always_ff @(posedge i_arb_gck) begin
    if (i_arb_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      gnt_q   <= 2'b00;
      wr_q    <= 1'b0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_gnt != 2'b00) begin
            state_q <= CMD;
            cnt_q   <= CMD_LAST;
            gnt_q   <= rr_gnt;
            wr_q    <= sel_wr;
            shift_q <= {(sel_wr ? SQI_CMD_WRITE : SQI_CMD_READ), ADDR_BITS'(sel_addr)};
          end
        end
        CMD: begin
          shift_q <= {shift_q[SH_W-5:0], 4'h0};
          if (last_cnt) begin
            state_q <= ADDR;
            cnt_q   <= ADDR_LAST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ADDR: begin
          shift_q <= {shift_q[SH_W-5:0], 4'h0};
          if (last_cnt) begin
            state_q <= wr_q ? DATA : DUMMY;
            cnt_q   <= wr_q ? WORD_LAST : DUMMY_LAST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DUMMY: begin
          if (last_cnt) begin
            state_q <= DATA;
            cnt_q   <= WORD_LAST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DATA: begin
          if (last_cnt) begin
            state_q <= DESEL;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DESEL: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // Read nibbles are registered, so each one appears the cycle after DATA.
  always_ff @(posedge i_arb_gck) begin
    if (i_arb_rst) begin
      o_arb_rd_data <= 4'h0;
      o_arb_rd_vld  <= 1'b0;
    end else begin
      o_arb_rd_vld <= rd_sample;
      if (rd_sample) begin
        o_arb_rd_data <= i_arb_sio;
      end
    end
  end

  // Pad-side controls decoded from the current phase.
  always_comb begin
    o_arb_cs     = 1'b1;
    o_arb_sio_oe = 1'b0;
    o_arb_sio    = 4'h0;
    o_arb_wr_acp = 1'b0;
    o_arb_done   = 1'b0;
    case (state_q)
      CMD, ADDR: begin
        o_arb_cs     = 1'b0;
        o_arb_sio_oe = 1'b1;
        o_arb_sio    = shift_q[SH_W-1 -: 4];
      end
      DUMMY: begin
        o_arb_cs = 1'b0;
      end
      DATA: begin
        o_arb_cs = 1'b0;
        if (wr_q) begin
          o_arb_sio_oe = 1'b1;
          o_arb_sio    = i_arb_wr_data[gnt_q[1]];
          o_arb_wr_acp = 1'b1;
        end
      end
      DESEL: begin
        o_arb_done = 1'b1;
      end
      default: begin
        o_arb_cs = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Self-checking bench for idli_sqi_arb_m: directed table, hand-written
// corner sequences and randomized traffic against a trace-based model.
module tb_idli_sqi_arb_m;
  import idli_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       wr;
  logic [1:0][15:0] addr;
  sqi_data_t [1:0]  wr_data;
  logic [3:0]       mem_sio;

  logic [1:0] gnt;
  logic [3:0] rd_data;
  logic       rd_vld, wr_acp, done, cs, sio_oe;
  logic [3:0] sio;

  always #5 clk = ~clk;

  idli_sqi_arb_m dut (
    .i_arb_gck     (clk),
    .i_arb_rst     (rst),
    .i_arb_req     (req),
    .i_arb_wr      (wr),
    .i_arb_addr    (addr),
    .i_arb_wr_data (wr_data),
    .o_arb_gnt     (gnt),
    .o_arb_rd_data (rd_data),
    .o_arb_rd_vld  (rd_vld),
    .o_arb_wr_acp  (wr_acp),
    .o_arb_done    (done),
    .o_arb_cs      (cs),
    .o_arb_sio     (sio),
    .o_arb_sio_oe  (sio_oe),
    .i_arb_sio     (mem_sio)
  );

  // Expected pad/requester view for one cycle.
  typedef struct {
    logic       cs;
    logic [1:0] gnt;
    logic [3:0] sio;
    logic       oe;
    logic       rd_vld;
    logic       wr_acp;
    logic       done;
    bit         sio_from_wr;
  } exp_t;

  // Directed access: inputs plus hand-derived expectations.
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] data;
    logic [1:0]  egnt;
    logic [31:0] ehdr;
    int          ecs;
    int          edone;
  } vec_t;

  exp_t       exp_q[$];
  int         last_id;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [3:0] prev_sio;

  logic       obs_cs, obs_oe, obs_vld, obs_acp, obs_done;
  logic [1:0] obs_gnt;
  logic [3:0] obs_sio, obs_rd;

  function automatic exp_t mk(logic c, logic [1:0] g, logic [3:0] s, logic o,
                              logic v, logic a, logic d, bit fw);
    exp_t e;
    e.cs = c; e.gnt = g; e.sio = s; e.oe = o;
    e.rd_vld = v; e.wr_acp = a; e.done = d; e.sio_from_wr = fw;
    return e;
  endfunction

  // Queue the cycle-by-cycle trace of one access starting next cycle.
  task automatic pushAccess(input int id, input logic w, input logic [15:0] a);
    logic [31:0] hdr;
    logic [1:0]  g;
    g   = (id == 0) ? 2'b01 : 2'b10;
    hdr = {(w ? 8'h02 : 8'h03), 8'h00, a};
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b0, g, hdr[31-4*i -: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    if (!w) for (int i = 0; i < 2; i++) exp_q.push_back(mk(1'b0, g, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      if (w) exp_q.push_back(mk(1'b0, g, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
      else   exp_q.push_back(mk(1'b0, g, 4'h0, 1'b0, (i > 0), 1'b0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(1'b1, g, 4'h0, 1'b0, !w, 1'b0, 1'b1, 1'b0));
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic checkOutput();
    exp_t       e;
    logic [3:0] esio;
    bit         bad;
    bit         was_idle;
    int         id;
    cyc++;
    obs_cs = cs; obs_oe = sio_oe; obs_vld = rd_vld; obs_acp = wr_acp;
    obs_done = done; obs_gnt = gnt; obs_sio = sio; obs_rd = rd_data;
    was_idle = (exp_q.size() == 0);
    if (was_idle) e = mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    else          e = exp_q.pop_front();
    esio = e.sio_from_wr ? wr_data[e.gnt[1]] : e.sio;
    bad = (obs_cs !== e.cs) || (obs_gnt !== e.gnt) || (obs_sio !== esio) ||
          (obs_oe !== e.oe) || (obs_vld !== e.rd_vld) || (obs_acp !== e.wr_acp) ||
          (obs_done !== e.done) || (e.rd_vld && (obs_rd !== prev_sio));
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL cycle %0d model: got cs=%b gnt=%b sio=%h oe=%b vld=%b rd=%h acp=%b done=%b, expected cs=%b gnt=%b sio=%h oe=%b vld=%b rd=%h acp=%b done=%b",
               cyc, obs_cs, obs_gnt, obs_sio, obs_oe, obs_vld, obs_rd, obs_acp, obs_done,
               e.cs, e.gnt, esio, e.oe, e.rd_vld, prev_sio, e.wr_acp, e.done);
    end
    if (rst) begin
      exp_q.delete();
      last_id = 1;
    end else if (was_idle && (req != 2'b00)) begin
      if (req == 2'b11) id = (last_id == 0) ? 1 : 0;
      else              id = req[1] ? 1 : 0;
      last_id = id;
      pushAccess(id, wr[id], addr[id]);
    end
    prev_sio = mem_sio;
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_timeout: got %0d pending cycles, expected 0", exp_q.size());
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [15:0] a0, input logic [15:0] a1);
    req = r; wr = w; addr[0] = a0; addr[1] = a1;
  endtask

  vec_t        vecs[4];
  logic [31:0] hdr_obs;
  logic [15:0] rd_obs, dw;
  int          cs_low, done_c, gnt_c, acp_n, ng, ngap, run, dones;
  logic [1:0]  gnt_obs, prev_g;
  logic [1:0]  gs[4];
  int          gaps[3];
  bit          seen_low, vw;

  initial begin
    vecs[0] = '{2'b01, 2'b00, 16'h1234, 16'h0000, 16'hC3A5, 2'b01, 32'h03001234, 14, 15};
    vecs[1] = '{2'b10, 2'b10, 16'h0000, 16'h00FF, 16'h4321, 2'b10, 32'h020000FF, 12, 13};
    vecs[2] = '{2'b11, 2'b01, 16'hBEEF, 16'h5555, 16'h9876, 2'b01, 32'h0200BEEF, 12, 13};
    vecs[3] = '{2'b11, 2'b00, 16'h7777, 16'hF00D, 16'h0F1E, 2'b10, 32'h0300F00D, 14, 15};

    last_id  = 1;
    prev_sio = 4'h0;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    wr_data = '0;
    mem_sio = 4'h0;
    @(posedge clk);
    #1;
    tick();
    checkVal("reset cs", {31'd0, obs_cs}, 32'd1);
    checkVal("reset gnt", {30'd0, obs_gnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed table of single accesses.
    for (int v = 0; v < 4; v++) begin
      waitIdle();
      applyStimulus(vecs[v].req, vecs[v].wr, vecs[v].a0, vecs[v].a1);
      wr_data = '0;
      mem_sio = 4'h0;
      tick();
      req = 2'b00;
      vw = vecs[v].wr[vecs[v].egnt[1]];
      dw = vecs[v].data;
      hdr_obs = '0; rd_obs = '0; cs_low = 0; done_c = 0; acp_n = 0; gnt_obs = 2'b00;
      for (int c = 1; c <= 16; c++) begin
        wr_data = '0;
        mem_sio = 4'h0;
        if (c >= 9 && c <= 12) begin
          wr_data[0] = dw[4*(c-9) +: 4];
          wr_data[1] = dw[4*(c-9) +: 4];
        end
        if (c >= 11 && c <= 14) mem_sio = dw[4*(c-11) +: 4];
        tick();
        if (c == 1) gnt_obs = obs_gnt;
        if (c <= 8) hdr_obs = {hdr_obs[27:0], obs_sio};
        if (!obs_cs) cs_low++;
        if (obs_done) done_c = c;
        if (obs_vld) rd_obs = {obs_rd, rd_obs[15:4]};
        if (obs_acp) acp_n++;
      end
      checkVal($sformatf("vec%0d gnt", v), {30'd0, gnt_obs}, {30'd0, vecs[v].egnt});
      checkVal($sformatf("vec%0d header", v), hdr_obs, vecs[v].ehdr);
      checkVal($sformatf("vec%0d cs_low", v), cs_low, vecs[v].ecs);
      checkVal($sformatf("vec%0d done_cycle", v), done_c, vecs[v].edone);
      if (vw) checkVal($sformatf("vec%0d wr_acp", v), acp_n, 4);
      else    checkVal($sformatf("vec%0d rd_word", v), {16'd0, rd_obs}, {16'd0, dw});
    end

    // Both requesting from reset: grants alternate with a 2-cycle CS gap.
    waitIdle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 16'h0100, 16'h0200);
    ng = 0; ngap = 0; run = 0; seen_low = 0; prev_g = 2'b00;
    for (int i = 0; i < 4; i++) gs[i] = 2'b00;
    for (int i = 0; i < 3; i++) gaps[i] = 0;
    for (int c = 0; c < 75; c++) begin
      tick();
      if (obs_gnt != 2'b00 && prev_g == 2'b00 && ng < 4) begin
        gs[ng] = obs_gnt;
        ng++;
      end
      prev_g = obs_gnt;
      if (obs_cs) run++;
      else begin
        if (seen_low && run > 0 && ngap < 3) begin
          gaps[ngap] = run;
          ngap++;
        end
        run = 0;
        seen_low = 1;
      end
    end
    checkVal("alt grant0", {30'd0, gs[0]}, 32'd1);
    checkVal("alt grant1", {30'd0, gs[1]}, 32'd2);
    checkVal("alt grant2", {30'd0, gs[2]}, 32'd1);
    checkVal("alt grant3", {30'd0, gs[3]}, 32'd2);
    for (int i = 0; i < 3; i++) checkVal($sformatf("alt gap%0d", i), gaps[i], 2);
    req = 2'b00;
    waitIdle();

    // LSU drops request and changes address mid-access.
    applyStimulus(2'b10, 2'b00, 16'h0000, 16'h0ABC);
    tick();
    hdr_obs = '0; ng = 0; dones = 0; prev_g = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        req = 2'b00;
        addr[1] = 16'hFFFF;
      end
      tick();
      if (c <= 8) hdr_obs = {hdr_obs[27:0], obs_sio};
      if (obs_gnt != 2'b00 && prev_g == 2'b00) ng++;
      prev_g = obs_gnt;
      if (obs_done) dones++;
    end
    checkVal("drop header", hdr_obs, 32'h03000ABC);
    checkVal("drop grants", ng, 1);
    checkVal("drop dones", dones, 1);
    waitIdle();

    // Reset during the DATA phase of a fetch read.
    applyStimulus(2'b01, 2'b00, 16'h1111, 16'h2222);
    tick();
    req = 2'b00;
    for (int c = 1; c <= 11; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    checkVal("post_reset cs", {31'd0, obs_cs}, 32'd1);
    checkVal("post_reset gnt", {30'd0, obs_gnt}, 32'd0);
    checkVal("post_reset rd_vld", {31'd0, obs_vld}, 32'd0);
    req = 2'b00;
    tick();
    checkVal("post_reset first grant", {30'd0, obs_gnt}, 32'd1);
    waitIdle();

    // Request raised during DESEL is granted two cycles after done.
    applyStimulus(2'b10, 2'b10, 16'h0003, 16'h0042);
    tick();
    req = 2'b00;
    done_c = 0; gnt_c = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 13) req = 2'b01;
      tick();
      if (obs_done && done_c == 0) done_c = c;
      if (obs_gnt == 2'b01 && gnt_c == 0) begin
        gnt_c = c;
        req = 2'b00;
      end
    end
    checkVal("desel_req done_cycle", done_c, 13);
    checkVal("desel_req grant_cycle", gnt_c, 15);
    req = 2'b00;
    waitIdle();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) req = 2'($urandom_range(0, 3));
      wr         = 2'($urandom_range(0, 3));
      addr[0]    = 16'($urandom);
      addr[1]    = 16'($urandom);
      wr_data[0] = 4'($urandom_range(0, 15));
      wr_data[1] = 4'($urandom_range(0, 15));
      mem_sio    = 4'($urandom_range(0, 15));
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req = 2'b00;
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
